// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the VRAM read port between render (strict priority), game logic and the
// level loader (round-robin). Optional logic/loader starvation guard: define VRAM_ARB_STARVE_EN.
module vram_arbiter #(
  parameter int AW         = 19,
  parameter int DW         = 12,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 16
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          r_req,
  input  logic [AW-1:0] r_addr,
  output logic          r_gnt,
  input  logic          g_req,
  input  logic [AW-1:0] g_addr,
  output logic          g_gnt,
  input  logic          l_req,
  input  logic [AW-1:0] l_addr,
  output logic          l_gnt,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata,
  output logic [2:0]    rvalid
);

  typedef enum logic [1:0] {
    SRC_R = 2'd0,
    SRC_G = 2'd1,
    SRC_L = 2'd2
  } src_t;

  logic          last;       // 0 = logic served last, 1 = loader served last
  logic          rr_pick_l;
  logic          any_gnt;
  logic [AW-1:0] gnt_addr;
  src_t          gnt_src;
  src_t          mem_tag;

  logic [RD_LAT-1:0] pipe_v;
  src_t              pipe_tag [RD_LAT];

  assign rr_pick_l = l_req && (!g_req || !last);

`ifdef VRAM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIM + 1);

  logic [CW-1:0] g_wait;
  logic [CW-1:0] l_wait;
  logic          g_starve;
  logic          l_starve;

  assign g_starve = g_req && (g_wait >= CW'(STARVE_LIM));
  assign l_starve = l_req && (l_wait >= CW'(STARVE_LIM));

  // Saturating wait counters; cleared whenever the requester is served.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      g_wait <= '0;
      l_wait <= '0;
    end else begin
      if (g_gnt)
        g_wait <= '0;
      else if (g_req && (g_wait != CW'(STARVE_LIM)))
        g_wait <= g_wait + 1'b1;

      if (l_gnt)
        l_wait <= '0;
      else if (l_req && (l_wait != CW'(STARVE_LIM)))
        l_wait <= l_wait + 1'b1;
    end
  end
`endif

  always_comb begin
    r_gnt = 1'b0;
    g_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!clrn) begin
`ifdef VRAM_ARB_STARVE_EN
      if (g_starve || l_starve) begin
        if (l_starve && (!g_starve || !last))
          l_gnt = 1'b1;
        else
          g_gnt = 1'b1;
      end else
`endif
      if (r_req)
        r_gnt = 1'b1;
      else if (rr_pick_l)
        l_gnt = 1'b1;
      else if (g_req)
        g_gnt = 1'b1;
    end
  end

  always_comb begin
    gnt_src  = SRC_R;
    gnt_addr = r_addr;
    if (g_gnt) begin
      gnt_src  = SRC_G;
      gnt_addr = g_addr;
    end else if (l_gnt) begin
      gnt_src  = SRC_L;
      gnt_addr = l_addr;
    end
  end

  assign any_gnt = r_gnt | g_gnt | l_gnt;

  // Issue stage: mem_en doubles as the valid bit of the first pipeline stage.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      mem_en   <= 1'b0;
      mem_addr <= '0;
      mem_tag  <= SRC_R;
      last     <= 1'b1;
    end else begin
      mem_en <= any_gnt;
      if (any_gnt) begin
        mem_addr <= gnt_addr;
        mem_tag  <= gnt_src;
      end
      if (g_gnt)
        last <= 1'b0;
      else if (l_gnt)
        last <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_tag[i] <= SRC_R;
      end
    end else begin
      pipe_v[0]   <= mem_en;
      pipe_tag[0] <= mem_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // Last stage lines up with mem_rdata; register it out as a one-hot response.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      rdata  <= '0;
      rvalid <= 3'b000;
    end else begin
      rvalid <= 3'b000;
      if (pipe_v[RD_LAT-1]) begin
        rvalid <= 3'b001 << pipe_tag[RD_LAT-1];
        rdata  <= mem_rdata;
      end
    end
  end

endmodule
